// File: rtl/btn_conditioner_pkg.sv
// btn_conditioner_pkg: shared constant helpers for the input conditioner.
package btn_conditioner_pkg;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v)
            r++;
        return r;
    endfunction

endpackage

// File: rtl/btn_conditioner_sync_chain.sv
// sync_chain: STAGES-deep flop chain bringing one asynchronous bit into the clk domain.
module sync_chain #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_d,
    output logic o_q
);
    logic [STAGES-1:0] r_q;

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n)
            r_q <= '0;
        else
            r_q <= {r_q[STAGES-2:0], i_d};

    assign o_q = r_q[STAGES-1];
endmodule

// File: rtl/btn_conditioner.sv
// btn_conditioner: per-channel synchroniser, tick-gated debounce and registered
// rise/fall strobes for buttons and switches.
module btn_conditioner
    import btn_conditioner_pkg::*;
#(
    parameter int CHANNELS        = 4,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int CNT_W           = clog2(DEBOUNCE_CYCLES + 1)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [CHANNELS-1:0] async_sig,
    input  logic                tick,
    output logic [CHANNELS-1:0] level,
    output logic [CHANNELS-1:0] rise,
    output logic [CHANNELS-1:0] fall,
    output logic                any_rise
);
    logic [CHANNELS-1:0] w_s;
    logic [CHANNELS-1:0] w_acc;
    logic [CHANNELS-1:0] r_level;
    logic [CHANNELS-1:0] r_rise;
    logic [CHANNELS-1:0] r_fall;
    logic                r_any_rise;

    genvar i;
    generate
        for (i = 0; i < CHANNELS; i++) begin : g_ch
            logic [CNT_W-1:0] r_cnt;

            sync_chain #(.STAGES(SYNC_STAGES)) u_sync (
                .clk   (clk),
                .rst_n (rst_n),
                .i_d   (async_sig[i]),
                .o_q   (w_s[i])
            );

            // accept on the tick that completes DEBOUNCE_CYCLES consecutive mismatching ticks
            assign w_acc[i] = tick && (w_s[i] != r_level[i]) &&
                              (r_cnt == CNT_W'(DEBOUNCE_CYCLES - 1));

            always_ff @(posedge clk or negedge rst_n)
                if (!rst_n)
                    r_cnt <= '0;
                else if (w_s[i] == r_level[i] || w_acc[i])
                    r_cnt <= '0;
                else if (tick)
                    r_cnt <= r_cnt + 1'b1;
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            r_level    <= '0;
            r_rise     <= '0;
            r_fall     <= '0;
            r_any_rise <= 1'b0;
        end else begin
            r_level    <= r_level ^ w_acc;
            r_rise     <= w_acc & w_s;
            r_fall     <= w_acc & ~w_s;
            r_any_rise <= |(w_acc & w_s);
        end

    assign level    = r_level;
    assign rise     = r_rise;
    assign fall     = r_fall;
    assign any_rise = r_any_rise;
endmodule

// File: tb/tb_btn_conditioner.sv
// tb_btn_conditioner: directed scenarios plus random stimulus against a
// behavioural model of delay-line synchroniser and tick-run debounce.
module tb_btn_conditioner;
    localparam int CH = 4;
    localparam int SS = 2;
    localparam int DC = 16;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          tick = 1'b0;
    logic [CH-1:0] async_sig = '0;
    logic [CH-1:0] level, rise, fall;
    logic          any_rise;

    always #5 clk = ~clk;

    btn_conditioner #(.CHANNELS(CH), .SYNC_STAGES(SS), .DEBOUNCE_CYCLES(DC)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .async_sig (async_sig),
        .tick      (tick),
        .level     (level),
        .rise      (rise),
        .fall      (fall),
        .any_rise  (any_rise)
    );

    int n_vec = 0;
    int n_err = 0;

    // model: input seen through an SS-edge delay line; a new value is taken once
    // it has been present on DC tick strobes in a row
    logic [CH-1:0] m_hist [SS];
    logic [CH-1:0] m_level, m_rise, m_fall;
    int            m_run [CH];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_clear;
        for (int k = 0; k < SS; k++) m_hist[k] = '0;
        for (int c = 0; c < CH; c++) m_run[c] = 0;
        m_level = '0;
        m_rise  = '0;
        m_fall  = '0;
    endtask

    task automatic cyc;
        logic [CH-1:0] s;
        @(posedge clk);
        if (!rst_n)
            model_clear();
        else begin
            s = m_hist[SS-1];
            m_rise = '0;
            m_fall = '0;
            for (int c = 0; c < CH; c++) begin
                if (s[c] == m_level[c])
                    m_run[c] = 0;
                else if (tick) begin
                    m_run[c]++;
                    if (m_run[c] == DC) begin
                        m_level[c] = s[c];
                        m_run[c]   = 0;
                        m_rise[c]  = s[c];
                        m_fall[c]  = ~s[c];
                    end
                end
            end
            for (int k = SS - 1; k > 0; k--) m_hist[k] = m_hist[k-1];
            m_hist[0] = async_sig;
        end
        @(negedge clk);
        chk("level", 32'(level), 32'(m_level));
        chk("rise", 32'(rise), 32'(m_rise));
        chk("fall", 32'(fall), 32'(m_fall));
        chk("any_rise", 32'(any_rise), 32'(|m_rise));
    endtask

    initial begin
        int pulses, anyc, lat;
        logic [CH-1:0] cap;
        model_clear();
        // reset held with all inputs high
        async_sig = 4'hF;
        tick = 1'b1;
        #2;
        chk("rst_level", 32'(level), 0);
        chk("rst_pulses", 32'({rise, fall, any_rise}), 0);
        repeat (3) cyc();
        rst_n = 1'b1;
        for (int e = 1; e <= 18; e++) begin
            cyc();
            if (e == 17) chk("lat_pre_level", 32'(level), 0);
            if (e == 18) begin
                chk("lat_level", 32'(level), 32'hF);
                chk("lat_rise", 32'(rise), 32'hF);
                chk("lat_any", 32'(any_rise), 1);
                chk("model_lat", 32'(m_level), 32'hF);
            end
        end
        cyc();
        chk("rise_one_cycle", 32'(rise), 0);
        // fall path on ch1
        async_sig = 4'b1101;
        pulses = 0;
        for (int e = 1; e <= 18; e++) begin
            cyc();
            pulses += int'(rise[1]);
            if (e == 17) chk("fall_pre", 32'(fall), 0);
            if (e == 18) chk("fall_edge18", 32'(fall), 32'b0010);
        end
        cyc();
        chk("fall_one_cycle", 32'(fall), 0);
        chk("fall_no_rise", 32'(pulses), 0);
        async_sig = '0;
        repeat (25) cyc();
        // bounce on ch0
        pulses = 0;
        async_sig[0] = 1'b1; repeat (10) begin cyc(); pulses += int'(rise[0]) + int'(fall[0]); end
        async_sig[0] = 1'b0; repeat (3)  begin cyc(); pulses += int'(rise[0]) + int'(fall[0]); end
        async_sig[0] = 1'b1; repeat (10) begin cyc(); pulses += int'(rise[0]) + int'(fall[0]); end
        async_sig[0] = 1'b0; repeat (25) begin cyc(); pulses += int'(rise[0]) + int'(fall[0]); end
        chk("bounce_level", 32'(level[0]), 0);
        chk("bounce_pulses", 32'(pulses), 0);
        // tick gating on ch2
        pulses = 0;
        async_sig[2] = 1'b1;
        for (int n = 0; n < 200; n++) begin
            tick = (n % 8 == 0);
            cyc();
            pulses += int'(rise[2]);
        end
        chk("tick_rise_count", 32'(pulses), 1);
        chk("tick_level", 32'(level[2]), 1);
        // simultaneous rises on ch0 and ch3
        tick = 1'b1;
        async_sig = 4'b1101;
        anyc = 0;
        cap = '0;
        repeat (25) begin
            cyc();
            if (any_rise) begin anyc++; cap = rise; end
        end
        chk("simul_any_count", 32'(anyc), 1);
        chk("simul_rise", 32'(cap), 32'b1001);
        async_sig = '0;
        repeat (25) cyc();
        // reset in the middle of ch0 debounce
        async_sig[0] = 1'b1;
        repeat (10) cyc();
        rst_n = 1'b0;
        model_clear();
        #1;
        chk("midrst_level", 32'(level), 0);
        chk("midrst_pulses", 32'({rise, fall, any_rise}), 0);
        repeat (2) cyc();
        @(negedge clk);
        rst_n = 1'b1;
        lat = 0;
        for (int e = 1; e <= 30 && lat == 0; e++) begin
            cyc();
            if (rise[0]) lat = e;
        end
        chk("midrst_latency", 32'(lat), 18);
        // random traffic with bounces, sparse ticks and rare resets
        for (int n = 0; n < 4000; n++) begin
            for (int c = 0; c < CH; c++)
                if ($urandom_range(0, 19) == 0) async_sig[c] = ~async_sig[c];
            tick = ($urandom_range(0, 3) != 0);
            rst_n = ($urandom_range(0, 599) != 0);
            cyc();
        end
        rst_n = 1'b1;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/btn_conditioner.md
Name: btn_conditioner

Overview:
- Multi-channel input conditioner for push-buttons and switches in the slot-machine front end.
- Per channel: multi-flop synchroniser, tick-gated debounce, then registered rise/fall pulse generation.
- Output is a clean level plus one-cycle edge strobes for the game FSM.
- Generalises the single-channel 3-flop edge detector: channel count, sync depth and debounce time are parameters, and bounce rejection is added.

Parameters:
- CHANNELS, 4: number of independent input channels (>=1).
- SYNC_STAGES, 2: synchroniser flops per channel (>=2).
- DEBOUNCE_CYCLES, 16: consecutive ticks a new value must persist before it is accepted (>=1).
- CNT_W, $clog2(DEBOUNCE_CYCLES+1): debounce counter width. Derived; must not be overridden.

Ports:
- clk  in  1  system clock; all flops on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- async_sig  in  CHANNELS  raw asynchronous inputs; bit i is channel i.
- tick  in  1  debounce sample strobe, one clk wide (e.g. 1 kHz enable); tie to 1 for per-clock debounce.
- level  out  CHANNELS  debounced, synchronised level.
- rise  out  CHANNELS  one-cycle pulse when level[i] goes 0->1.
- fall  out  CHANNELS  one-cycle pulse when level[i] goes 1->0.
- any_rise  out  1  registered OR of all rise bits, same cycle as rise.

Behaviour:
- Reset (rst_n=0, async): all sync flops, level, rise, fall, any_rise and counters go to 0 immediately, and stay 0 while reset is held.
- Synchroniser: per channel a SYNC_STAGES-deep shift chain. s = last stage. No logic between stages.
- Debounce, per channel, every clk edge:
  - s == level[i]: counter cleared to 0.
  - s != level[i], tick=0: counter holds.
  - s != level[i], tick=1, counter < DEBOUNCE_CYCLES-1: counter increments.
  - s != level[i], tick=1, counter == DEBOUNCE_CYCLES-1: level[i] <= s, counter cleared.
- Bounce: any return of s to level[i] before acceptance clears the counter. A glitch shorter than DEBOUNCE_CYCLES ticks never changes level.
- Latency with tick=1: input changes and is then held. level[i] updates on edge SYNC_STAGES+DEBOUNCE_CYCLES, counting the first edge that samples the new value as edge 1. Defaults give 18.
- Edges: rise[i]/fall[i] are asserted in the same cycle level[i] takes its new value, for exactly one cycle. They are registered, not combinational from level.
- rise[i] and fall[i] are never both 1.
- any_rise is registered alongside rise.
- Channels are fully independent. Simultaneous acceptance on several channels gives simultaneous pulses.
- Counter saturates by construction (cleared on accept); no wrap-around possible.
- Post-reset: level starts at 0. An input held high through reset produces a rise pulse after normal latency. This is intended; the game FSM ignores the first press.
- Reset asserted mid-debounce: counter discarded; the debounce restarts from 0 after release.
- tick asserted continuously, or coincident with reset release: no special casing.

Decomposition:
- Shared package holds no typedefs for this block.
- The clog2 helper lives in the common utility package.
- One sub-module is natural: sync_chain (parameter STAGES, 1-bit in/out, rst_n async clear), instantiated per channel in a generate loop.
- Debounce and edge logic stay in btn_conditioner as a per-channel generate body.

Test Plan:
- Reset values: rst_n=0 with async_sig=4'hF -> level, rise, fall and any_rise all 0. Release with tick=1 and defaults -> level=4'hF and rise=4'hF for one cycle on edge 18, any_rise=1 the same cycle.
- Bounce rejection, tick=1, DEBOUNCE_CYCLES=16: ch0 toggles high 10 cycles, low 3, high 10, low -> level[0] stays 0, no rise/fall pulses.
- Tick gating: tick one cycle in 8, ch2 held high -> level[2] rises only after 16 tick strobes following sync. Counter holds between ticks; exactly one rise[2] pulse.
- Fall path: ch1 accepted high then driven low and held -> fall[1]=1 for one cycle at edge 18 after the change; rise[1]=0 throughout.
- Simultaneous channels: ch0 and ch3 go high in the same cycle -> rise=4'b1001 in one cycle, any_rise=1 once.
- Mid-operation reset: ch0 high, rst_n pulsed low at edge 10 of the debounce -> outputs 0 at once. After release a full 18-edge latency applies before rise[0].
